fetch_buffer: RTL
=================

Name: fetch_buffer

Overview:
Multi-lane instruction FIFO between the fetch stage and the if_to_id/decode path. It decouples the fetch group width from the number of instructions decode accepts per cycle, and gives pc_select a backpressure signal. It accepts 0-4 fetched instructions per cycle, presents up to 4 oldest entries to decode in program order, and is cleared by a pipeline flush.

Parameters:
DEPTH, 8, number of entries; power of two, >= 8.
DATA_W, 64, width of one instruction entry (packed DECODE_REQUIRE).
CNT_W, 4, occupancy counter width = log2(DEPTH)+1.

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  asynchronous active-high reset
flush  input  1  discard all contents (from control flash_to_if_id)
in_data  input  4*DATA_W  fetch group; lane 0 is oldest
in_num  input  3  valid lanes in in_data, 0-4, lanes 0..in_num-1 valid
in_ready  output  1  buffer can accept a full 4-lane group this cycle
out_data  output  4*DATA_W  oldest entries; lane 0 is head
out_num  output  3  valid output lanes = min(count,4)
pop_num  input  3  entries consumed by decode this cycle, 0-4
count  output  CNT_W  current occupancy
err  output  1  sticky protocol-violation flag

Behaviour:
- State: head pointer, tail pointer (each log2(DEPTH) bits, wrap modulo DEPTH), count register, sticky err, and DEPTH x DATA_W storage.
- Storage is not reset. Only pointers, count and err are reset.
- Reset (async, any time, including mid-operation): head=0, tail=0, count=0, err=0. Outputs then read in_ready=1, out_num=0, out_data=0.
- in_ready = (DEPTH - count) >= 4, computed from the registered count only. A same-cycle pop does not raise in_ready, so there is no combinational path from pop_num to in_ready.
- Push: push_eff = in_ready ? in_num : 0. in_num=1..4 with in_ready=0 is legal backpressure: data is ignored and err is not set. Upstream holds the pc.
- Push writes lane i (i < push_eff) to storage[(tail+i) mod DEPTH]. tail advances by push_eff.
- Output (combinational from registers): out_num = min(count,4). Lane i < out_num = storage[(head+i) mod DEPTH]. Lanes >= out_num are driven to 0.
- Pop: pop_eff = min(pop_num, out_num). head advances by pop_eff.
- Pop with pop_num > out_num is clamped and sets err.
- in_num > 4 is treated as push_eff=0 and sets err.
- err stays set until reset.
- Simultaneous push and pop: count_next = count + push_eff - pop_eff. Newly pushed entries become visible on out_data the following cycle; there is no bypass.
- Flush has highest priority. At the next edge: head=0, tail=0, count=0. That cycle's push and pop are discarded. err is unaffected and is not set by any input seen during a flush cycle.
- Wrap-around: pointer arithmetic is modulo DEPTH for writes, reads and advances. count distinguishes full from empty; count never exceeds DEPTH.
- Latency: a push at edge N is visible at out_data after edge N. Minimum fetch-to-decode latency is 1 cycle.

Test Plan:
- Reset mid-stream: push 4, assert rst asynchronously between edges -> count=0, out_num=0, out_data=0, in_ready=1 immediately, without waiting for a clock edge.
- Fill to full (DEPTH=8): push 4 tagged A0-A3, then B0-B3, with pop_num=0 -> count=8, in_ready=0, out_num=4, out_data=A0..A3. A third push of 4 with C tags is ignored: count stays 8 and err=0.
- Wrap-around: from full, pop 4; push C0-C3; then pop 4 twice -> out_data shows B0..B3 then C0..C3; tail ends at 4 and head at 4 (wrapped).
- Simultaneous push/pop: count=3 (D0-D2), push 2 (D3,D4) and pop 2 in the same cycle -> count=3 next cycle, out_num=3, out_data lanes = D2,D3,D4, lane 3 = 0.
- Flush priority: count=5, assert flush together with in_num=4 and pop_num=2 -> next cycle count=0, out_num=0, in_ready=1, err=0.
- Protocol violation: count=2, pop_num=4 -> only 2 entries popped, count=0, err=1; err remains 1 after a later flush and clears only on rst.

Source files
------------

// File: rtl/fetch_buffer.sv
// fetch_buffer: multi-lane instruction FIFO between fetch and decode.
// Accepts 0-4 instructions per cycle, presents the up-to-4 oldest entries
// in program order, and is cleared by a pipeline flush.
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   flush               discard all contents at the next edge
//   in_data, in_num     fetch group (lane 0 oldest) and its valid lane count
//   in_ready            a full 4-lane group can be accepted this cycle
//   out_data, out_num   oldest entries (lane 0 is head) and valid lane count
//   pop_num             entries consumed by decode this cycle
//   count               current occupancy
//   err                 sticky protocol-violation flag
module fetch_buffer #(
  parameter int unsigned DEPTH  = 8,
  parameter int unsigned DATA_W = 64,
  parameter int unsigned CNT_W  = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic [4*DATA_W-1:0]   in_data,
  input  logic [2:0]            in_num,
  output logic                  in_ready,
  output logic [4*DATA_W-1:0]   out_data,
  output logic [2:0]            out_num,
  input  logic [2:0]            pop_num,
  output logic [CNT_W-1:0]      count,
  output logic                  err
);

  localparam int unsigned LANES = 4;
  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam logic [CNT_W-1:0] READY_MAX = CNT_W'(DEPTH - LANES);

  logic [PTR_W-1:0]  head_q, head_d;
  logic [PTR_W-1:0]  tail_q, tail_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              err_q, err_d;
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] mem_d [DEPTH];

  logic [2:0] push_eff;
  logic [2:0] pop_eff;

  // Status and read-side view, derived from registered state only
  always_comb begin
    in_ready = (count_q <= READY_MAX);
    out_num  = (count_q >= CNT_W'(LANES)) ? 3'(LANES) : 3'(count_q);
    out_data = '0;
    for (int i = 0; i < int'(LANES); i++) begin
      if (3'(i) < out_num) begin
        out_data[i*DATA_W +: DATA_W] = mem_q[head_q + PTR_W'(i)];
      end
    end
  end

  // Next-state: push/pop clamping, error detection, flush priority
  always_comb begin
    push_eff = '0;
    pop_eff  = '0;
    head_d   = head_q;
    tail_d   = tail_q;
    count_d  = count_q;
    err_d    = err_q;
    mem_d    = mem_q;

    if (flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      // Oversized group is dropped entirely; backpressure alone is not an error
      if (in_num > 3'(LANES)) begin
        err_d = 1'b1;
      end else if (in_ready) begin
        push_eff = in_num;
      end

      if (pop_num > out_num) begin
        pop_eff = out_num;
        err_d   = 1'b1;
      end else begin
        pop_eff = pop_num;
      end

      for (int i = 0; i < int'(LANES); i++) begin
        if (3'(i) < push_eff) begin
          mem_d[tail_q + PTR_W'(i)] = in_data[i*DATA_W +: DATA_W];
        end
      end

      head_d  = head_q + PTR_W'(pop_eff);
      tail_d  = tail_q + PTR_W'(push_eff);
      count_d = count_q + CNT_W'(push_eff) - CNT_W'(pop_eff);
    end
  end

  // Control state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      err_q   <= 1'b0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      err_q   <= err_d;
    end
  end

  // Entry storage, intentionally not reset
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign count = count_q;
  assign err   = err_q;

endmodule
